// File: rtl/can_pkg.sv
// Shared types and constants for the classic CAN 2.0A transmitter.
package can_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOF,
        ST_ARB,
        ST_CTRL,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK,
        ST_ACK_DEL,
        ST_EOF,
        ST_IFS
    } can_state_e;

    localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

    localparam int ID_BITS     = 11;
    localparam int DLC_BITS    = 4;
    localparam int CRC_BITS    = 15;
    localparam int EOF_BITS    = 7;
    localparam int STUFF_LIMIT = 5;

    function automatic logic [3:0] dlc_bytes(input logic [3:0] dlc);
        return (dlc > 4'd8) ? 4'd8 : dlc;
    endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CRC-15 LFSR, one update per unstuffed frame bit.
module can_crc15
    import can_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [14:0] crc_o
);

    logic [14:0] crc_q;
    logic [14:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[13:0], 1'b0};
            if (bit_i ^ crc_q[14]) begin
                crc_d = crc_d ^ CAN_CRC_POLY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/can_tx_frame.sv
// CAN 2.0A frame transmitter: valid/ready request in, stuffed bitstream
// out, with arbitration-loss and ACK-slot monitoring on the RX pin.
module can_tx_frame
    import can_pkg::*;
#(
    parameter int CLK_PER_BIT = 100,
    parameter int SAMPLE_PT   = 70,
    parameter int IFS_BITS    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [10:0] tx_id,
    input  logic        tx_rtr,
    input  logic [3:0]  tx_dlc,
    input  logic [63:0] tx_data,
    input  logic        can_rx,
    output logic        can_tx,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        arb_lost
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_SMP  = CW'(SAMPLE_PT);

    can_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [6:0]   idx_q;
    logic [2:0]   run_q;
    logic         last_q;
    logic         stuff_q;
    logic         rx_q;
    logic         ack_ok_q;
    logic [10:0]  id_q;
    logic         rtr_q;
    logic [3:0]   dlc_q;
    logic [63:0]  data_q;
    logic         can_tx_q;
    logic         tx_ready_q;
    logic         busy_q;
    logic         done_q;
    logic         ack_err_q;
    logic         arb_lost_q;

    logic         accept;
    logic         eob;
    logic         arb_hit;
    logic [3:0]   nbytes;
    logic [6:0]   len_cur;
    logic         last_f;
    can_state_e   nxt_state;
    logic [6:0]   nxt_idx;
    logic         nxt_bit;
    logic [3:0]   id_sel;
    logic [1:0]   dlc_sel;
    logic [5:0]   data_sel;
    logic [3:0]   crc_sel;
    logic         in_stuff;
    logic [2:0]   run_n;
    logic         last_n;
    logic         do_stuff;
    logic         crc_en;
    logic [14:0]  crc;

    assign accept  = (state_q == ST_IDLE) && tx_valid && tx_ready_q;
    assign eob     = (cnt_q == CNT_LAST);
    assign arb_hit = (state_q == ST_ARB) && (cnt_q == CNT_SMP)
                     && can_tx_q && !can_rx;
    assign nbytes  = dlc_bytes(dlc_q);

    // Field sequencing: where the next unstuffed bit comes from.
    always_comb begin
        unique case (state_q)
            ST_ARB:  len_cur = 7'(ID_BITS + 1);
            ST_CTRL: len_cur = 7'(2 + DLC_BITS);
            ST_DATA: len_cur = {nbytes, 3'b000};
            ST_CRC:  len_cur = 7'(CRC_BITS);
            ST_EOF:  len_cur = 7'(EOF_BITS);
            ST_IFS:  len_cur = 7'(IFS_BITS);
            default: len_cur = 7'd1;
        endcase
        last_f    = (idx_q == len_cur - 7'd1);
        nxt_state = state_q;
        nxt_idx   = idx_q + 7'd1;
        if (last_f) begin
            nxt_idx = '0;
            unique case (state_q)
                ST_SOF:     nxt_state = ST_ARB;
                ST_ARB:     nxt_state = ST_CTRL;
                ST_CTRL:    nxt_state = (rtr_q || nbytes == 4'd0)
                                        ? ST_CRC : ST_DATA;
                ST_DATA:    nxt_state = ST_CRC;
                ST_CRC:     nxt_state = ST_CRC_DEL;
                ST_CRC_DEL: nxt_state = ST_ACK;
                ST_ACK:     nxt_state = ST_ACK_DEL;
                ST_ACK_DEL: nxt_state = ST_EOF;
                ST_EOF:     nxt_state = (IFS_BITS == 0) ? ST_IDLE : ST_IFS;
                default:    nxt_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        id_sel   = 4'd10 - nxt_idx[3:0];
        dlc_sel  = 2'(3'd5 - nxt_idx[2:0]);
        data_sel = 6'd63 - nxt_idx[5:0];
        crc_sel  = 4'd14 - nxt_idx[3:0];
        unique case (nxt_state)
            ST_SOF:  nxt_bit = 1'b0;
            ST_ARB:  nxt_bit = (nxt_idx < 7'(ID_BITS)) ? id_q[id_sel] : rtr_q;
            ST_CTRL: nxt_bit = (nxt_idx < 7'd2) ? 1'b0 : dlc_q[dlc_sel];
            ST_DATA: nxt_bit = data_q[data_sel];
            ST_CRC:  nxt_bit = crc[crc_sel];
            default: nxt_bit = 1'b1;
        endcase
    end

    // A stuff bit restarts the run with its own value.
    always_comb begin
        in_stuff = state_q inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC};
        last_n   = can_tx_q;
        if (stuff_q) begin
            run_n = 3'd1;
        end else if (run_q != 3'd0 && can_tx_q == last_q) begin
            run_n = run_q + 3'd1;
        end else begin
            run_n = 3'd1;
        end
        do_stuff = in_stuff && !stuff_q && (run_n == 3'(STUFF_LIMIT));
        crc_en   = (state_q != ST_IDLE) && eob && !arb_hit && !do_stuff
                   && (nxt_state inside {ST_ARB, ST_CTRL, ST_DATA});
    end

    can_crc15 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .en_i  (crc_en),
        .bit_i (nxt_bit),
        .crc_o (crc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            run_q      <= '0;
            last_q     <= 1'b0;
            stuff_q    <= 1'b0;
            rx_q       <= 1'b1;
            ack_ok_q   <= 1'b0;
            id_q       <= '0;
            rtr_q      <= 1'b0;
            dlc_q      <= '0;
            data_q     <= '0;
            can_tx_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            arb_lost_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            arb_lost_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                cnt_q <= '0;
                if (accept) begin
                    id_q       <= tx_id;
                    rtr_q      <= tx_rtr;
                    dlc_q      <= tx_dlc;
                    data_q     <= tx_data;
                    state_q    <= ST_SOF;
                    idx_q      <= '0;
                    run_q      <= '0;
                    last_q     <= 1'b0;
                    stuff_q    <= 1'b0;
                    ack_ok_q   <= 1'b0;
                    can_tx_q   <= 1'b0;
                    tx_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
            end else if (arb_hit) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                can_tx_q   <= 1'b1;
                tx_ready_q <= 1'b1;
                busy_q     <= 1'b0;
                arb_lost_q <= 1'b1;
            end else begin
                cnt_q <= eob ? '0 : cnt_q + 1'b1;
                if (cnt_q == CNT_SMP) begin
                    rx_q <= can_rx;
                end
                if (eob) begin
                    if (state_q == ST_ACK) begin
                        ack_err_q <= rx_q;
                        ack_ok_q  <= !rx_q;
                    end
                    if (state_q == ST_EOF && last_f) begin
                        done_q <= ack_ok_q;
                    end
                    run_q  <= run_n;
                    last_q <= last_n;
                    if (do_stuff) begin
                        stuff_q  <= 1'b1;
                        can_tx_q <= ~can_tx_q;
                    end else begin
                        stuff_q  <= 1'b0;
                        state_q  <= nxt_state;
                        idx_q    <= nxt_idx;
                        can_tx_q <= nxt_bit;
                        if (nxt_state == ST_IDLE) begin
                            can_tx_q   <= 1'b1;
                            tx_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign can_tx   = can_tx_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ack_err  = ack_err_q;
    assign arb_lost = arb_lost_q;

endmodule
